// File: rtl/cpu_pkg.sv
// cpu_pkg: shared mode encodings and default datapath width for result-path muxes
package cpu_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
  localparam int DEF_WIDTH = 16;
endpackage

// File: rtl/mux_nway_stream_rr_arbiter.sv
// rr_arbiter: picks the first requester at or after ptr, wrapping, as one-hot grant and index
module rr_arbiter #(
  parameter int N = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] idx,
  output logic            found
);
  int j;
  always_comb begin
    idx = '0;
    found = 1'b0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        idx = SELW'(j);
        found = 1'b1;
      end
    end
    gnt = found ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/mux_nway_stream.sv
// mux_nway_stream: N-channel valid/ready mux, fixed-select or round-robin, into one registered stream
module mux_nway_stream
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan
);
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [N-1:0]     rr_gnt;
  logic [SELW-1:0]  rr_idx, g;
  logic             rr_found, sel_vld, load, grant;
  rr_arbiter #(.N(N)) u_arb (
    .req(in_valid), .ptr(rr_ptr_q), .gnt(rr_gnt), .idx(rr_idx), .found(rr_found)
  );
  always_comb begin
    load = !out_valid_q || out_ready;
    // shifting past the top channel yields zero, so sel >= N never grants
    sel_vld = ((in_valid >> sel) & N'(1)) != '0;
    g = (mode == MODE_RR) ? rr_idx : sel;
    grant = rst_n && load && ((mode == MODE_RR) ? rr_found : sel_vld);
    in_ready = grant ? N'(1) << g : '0;
    out_valid_d = load ? grant : out_valid_q;
    out_data_d = grant ? WIDTH'(in_data >> (int'(g) * WIDTH)) : out_data_q;
    out_chan_d = grant ? g : out_chan_q;
    rr_ptr_d = (grant && mode == MODE_RR) ? ((int'(g) == N - 1) ? '0 : g + 1'b1) : rr_ptr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_chan_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_chan = out_chan_q;
  wire unused_ok = &{1'b0, rr_gnt};
endmodule

// File: tb/tb_mux_nway_stream.sv
// tb_mux_nway_stream: directed vectors for the 4-channel build plus a 3-channel build for out-of-range sel
module tb_mux_nway_stream;
  logic        clk = 1'b0;
  logic        rst_n, mode, out_ready;
  logic [1:0]  sel, sel3;
  logic [3:0]  in_valid, in_ready;
  logic [63:0] in_data;
  logic        out_valid, out_valid3;
  logic [15:0] out_data, out_data3;
  logic [1:0]  out_chan, out_chan3;
  logic [2:0]  in_ready3;
  logic [15:0] dw [4];
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  mux_nway_stream #(.WIDTH(16), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan)
  );
  mux_nway_stream #(.WIDTH(16), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel3), .in_valid(in_valid[2:0]),
    .in_ready(in_ready3), .in_data(in_data[47:0]), .out_valid(out_valid3),
    .out_ready(out_ready), .out_data(out_data3), .out_chan(out_chan3)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string tag, input logic v, input logic [15:0] d, input logic [1:0] c);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"}, 32'(out_data), 32'(d));
    chk({tag, ".chan"}, 32'(out_chan), 32'(c));
  endtask
  initial begin
    dw[0] = 16'h000f; dw[1] = 16'h00f0; dw[2] = 16'h0f00; dw[3] = 16'hf000;
    in_data = {dw[3], dw[2], dw[1], dw[0]};
    rst_n = 1'b0; mode = 1'b0; sel = 2'd0; sel3 = 2'd0; in_valid = 4'hf; out_ready = 1'b1;
    tick(); tick();
    chk_out("reset", 1'b0, 16'h0000, 2'd0);
    chk("reset.in_ready", 32'(in_ready), 32'h0);
    rst_n = 1'b1; mode = 1'b1; #1;
    chk("rel.in_ready", 32'(in_ready), 32'h1);
    tick();
    chk_out("rel.first", 1'b1, dw[0], 2'd0);
    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      tick();
      chk_out($sformatf("fixed%0d", i), 1'b1, dw[i], 2'(i));
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1; mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_out($sformatf("rr%0d", i), 1'b1, dw[i % 4], 2'(i % 4));
    end
    in_valid = 4'b0001; tick();
    chk("rr.ptr_to1", 32'(out_chan), 32'd0);
    in_valid = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr_sparse%0d", i), 32'(out_chan), (i % 2 == 0) ? 32'd2 : 32'd0);
    end
    mode = 1'b0; in_valid = 4'hf; sel = 2'd1; tick();
    chk_out("bp.load", 1'b1, dw[1], 2'd1);
    out_ready = 1'b0; sel = 2'd2; #1;
    chk("bp.in_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("bp.hold%0d", i), 1'b1, dw[1], 2'd1);
      chk($sformatf("bp.in_ready%0d", i), 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1; #1;
    chk("bp.release_ready", 32'(in_ready), 32'h4);
    tick();
    chk_out("bp.nobubble", 1'b1, dw[2], 2'd2);
    sel = 2'd1; in_valid = 4'b1101; sel3 = 2'd2; #1;
    chk("empty.in_ready", 32'(in_ready), 32'h0);
    chk("n3.sel2_ready", 32'(in_ready3), 32'h4);
    tick();
    chk_out("empty.drop", 1'b0, dw[2], 2'd2);
    chk("n3.sel2_data", 32'(out_data3), 32'(dw[2]));
    sel3 = 2'd3; in_valid = 4'hf; #1;
    chk("n3.sel3_ready", 32'(in_ready3), 32'h0);
    tick();
    chk("n3.sel3_valid", 32'(out_valid3), 32'h0);
    chk("n3.sel3_hold", 32'(out_chan3), 32'd2);
    mode = 1'b1; tick();
    chk_out("sw.rr1", 1'b1, dw[1], 2'd1);
    mode = 1'b0; sel = 2'd3; tick();
    chk_out("sw.fixed", 1'b1, dw[3], 2'd3);
    mode = 1'b1; tick();
    chk_out("sw.resume", 1'b1, dw[2], 2'd2);
    rst_n = 1'b0; tick();
    chk_out("midrst", 1'b0, 16'h0000, 2'd0);
    rst_n = 1'b1; #1;
    chk("midrst.ptr", 32'(in_ready), 32'h1);
    tick();
    chk_out("midrst.after", 1'b1, dw[0], 2'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
